// File: rtl/alu_out_stage.sv
// alu_out_stage: registered output stage for a 32-bit adder.
// Holds up to two entries: a main output register and a skid register.
// in_ready depends only on registered state.
// Flags are captured as {N,Z,C,V}. The sticky overflow bit can be cleared.
// Optional macro ALU_OUT_STAGE_CNT_EN adds a saturating count of output transfers.
// When the macro is undefined, xfer_cnt is tied to zero.

module alu_out_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_sum,
    input  logic        in_cout,
    input  logic        in_zero,
    input  logic        in_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic        sticky_ovf,
    input  logic        clr_sticky,
    output logic [15:0] xfer_cnt
);

    // state | meaning
    // EMPTY | no entry held
    // ONE   | main register holds the oldest entry
    // FULL  | main holds the oldest entry, skid holds the next one
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        xfer;
    logic [3:0]  in_flags;
    logic [31:0] skid_result;
    logic [3:0]  skid_flags;

    // Z is passed through from the adder, not recomputed from the sum
    assign in_flags = {in_sum[31], in_zero, in_cout, in_ovf};
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !xfer)      state_nxt = FULL;
                else if (!accept && xfer) state_nxt = EMPTY;
            end
            FULL:    if (xfer) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        case (state)
            EMPTY:   begin in_ready = 1'b1; out_valid = 1'b0; end
            ONE:     begin in_ready = 1'b1; out_valid = 1'b1; end
            FULL:    begin in_ready = 1'b0; out_valid = 1'b1; end
            default: begin in_ready = 1'b1; out_valid = 1'b0; end
        endcase
    end

    // Main/skid data path; main is written directly whenever it is free or draining
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_result  <= 32'h0;
            out_flags   <= 4'h0;
            skid_result <= 32'h0;
            skid_flags  <= 4'h0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_result <= in_sum;
                        out_flags  <= in_flags;
                    end
                end
                ONE: begin
                    if (accept && xfer) begin
                        out_result <= in_sum;
                        out_flags  <= in_flags;
                    end else if (accept) begin
                        skid_result <= in_sum;
                        skid_flags  <= in_flags;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        out_result <= skid_result;
                        out_flags  <= skid_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overflow; a new overflow wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (!rst_n)                 sticky_ovf <= 1'b0;
        else if (accept && in_ovf)  sticky_ovf <= 1'b1;
        else if (clr_sticky)        sticky_ovf <= 1'b0;
    end

`ifdef ALU_OUT_STAGE_CNT_EN
    logic [15:0] cnt;

    // Saturating output-transfer counter, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n)                        cnt <= 16'h0000;
        else if (xfer && cnt != 16'hFFFF)  cnt <= cnt + 16'h0001;
    end

    assign xfer_cnt = cnt;
`else
    assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: doc/alu_out_stage.md
ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have port: in_valid  input  1  upstream 32-bit adder result valid.
REQ-004 SHALL have port: in_ready  output  1  stage can accept an input this cycle.
REQ-005 SHALL have port: in_sum  input  32  adder sum.
REQ-006 SHALL have port: in_cout / in_zero / in_ovf  input  1 each  adder carry-out, zero, signed overflow.
REQ-007 SHALL have port: out_valid  output  1  out_result/out_flags hold a valid entry.
REQ-008 SHALL have port: out_ready  input  1  downstream accepts the entry.
REQ-009 SHALL have port: out_result  output  32  registered sum.
REQ-010 SHALL have port: out_flags  output  4  {N,Z,C,V}.
REQ-011 SHALL have port: sticky_ovf  output  1  set by any accepted entry with V=1.
REQ-012 SHALL have port: clr_sticky  input  1  synchronous clear of sticky_ovf.
REQ-013 SHALL have port: xfer_cnt  output  16  count of output transfers (see Configuration).

Function
REQ-014 SHALL accept an input when in_valid && in_ready; transfer an output when out_valid && out_ready.
REQ-015 SHALL contain a main output register plus one skid register (2-entry depth); states EMPTY, ONE (main full), FULL (main+skid full).
REQ-016 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL, from registered state only (no comb path from out_ready).
REQ-017 SHALL present an accepted entry on out_* the cycle after acceptance when main is empty or transferring (latency 1).
REQ-018 SHALL write to skid when accepting in ONE with out_ready=0 (ONE->FULL).
REQ-019 SHALL move skid to main on transfer in FULL (FULL->ONE); in FULL no input is accepted.
REQ-020 In ONE with simultaneous accept and transfer, SHALL load new entry into main, stay ONE.
REQ-021 Transitions: EMPTY->ONE on accept; ONE->EMPTY on transfer without accept; all others hold.
REQ-022 SHALL preserve entry order; no entry dropped or duplicated.
REQ-023 SHALL hold out_result/out_flags stable while out_valid && !out_ready.
REQ-024 Flags: N = in_sum[31], Z = in_zero, C = in_cout, V = in_ovf, captured with the entry; Z passed through, not recomputed.
REQ-025 sticky_ovf SHALL set the cycle after accepting an entry with in_ovf=1; clr_sticky clears it; simultaneous set and clear -> set wins.

Reset
REQ-026 On rst_n=0 at clk edge: state EMPTY, out_valid=0, out_result=0, out_flags=0, sticky_ovf=0, xfer_cnt=0; in_ready=1 from the first cycle after reset.
REQ-027 Reset mid-operation SHALL discard both held entries; no output transfer occurs in the reset cycle.

Configuration
REQ-028 Macro ALU_OUT_STAGE_CNT_EN defined: xfer_cnt increments by 1 per output transfer, saturates at 0xFFFF, cleared only by reset.
REQ-029 Macro undefined: xfer_cnt tied to 16'h0000, no counter logic; all other behaviour identical.

Verification
REQ-030 Reset, then in_sum=0x0000_0005,cout=0,zero=0,ovf=0 with out_ready=1 -> next cycle out_valid=1, out_result=0x00000005, out_flags=4'b0000.
REQ-031 out_ready=0, push 0x11,0x22 back-to-back -> in_ready=0 after 2nd accept; release out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready=1 again.
REQ-032 Input sum=0x8000_0000,ovf=1,cout=1 -> out_flags=4'b1011, sticky_ovf=1; assert clr_sticky alone -> 0; clr_sticky with new ovf=1 accept -> stays 1.
REQ-033 Continuous in_valid/out_ready=1 for 100 incrementing values -> one result per cycle, in order; with ALU_OUT_STAGE_CNT_EN xfer_cnt=100, without it 0.
REQ-034 FULL state, then rst_n=0 one cycle -> out_valid=0, in_ready=1, sticky_ovf=0, xfer_cnt=0; held entries never appear.
REQ-035 With ALU_OUT_STAGE_CNT_EN, 65540 transfers -> xfer_cnt=0xFFFF (saturated).
